// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_e : sequencer state (IDLE, RUN, DONE)
//   OP_ADD  : operation select value for A+B
//   OP_SUB  : operation select value for A-B
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/fas.sv
// fas
// Single-bit full adder / full subtractor cell (functional model).
// Ports:
//   a, b  : operand bits
//   cin   : carry-in (add) or borrow-in (subtract)
//   a_ns  : 1 = add, 0 = subtract
//   s     : sum / difference bit
//   cout  : carry-out (add) or borrow-out of a-b-cin (subtract)
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  // Subtraction reuses the adder majority with a inverted: that is the
  // borrow of a-b-cin, while the difference bit equals the sum bit.
  logic a_eff;

  assign a_eff = a_ns ? a : ~a;
  assign s     = a ^ b ^ cin;
  assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial add/subtract sequencer around one fas cell. Operands are fed
// LSB first, one bit pair per clock; the carry/borrow is registered between
// bits and the sum bits are shifted into the result from the MSB end.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : request pulse, sampled only when not busy
//   a_ns_i     : 1 = add, 0 = subtract
//   a_i, b_i   : operands, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, result valid from this cycle on
//   result     : sum/difference modulo 2^WIDTH
//   carry      : final carry-out (add) or borrow-out (subtract)
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_ns_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             cy_q, cy_d;

  logic cell_s;
  logic cell_cout;

  fas u_fas (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .a_ns (op_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cy_q    <= cy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    cy_d    = cy_q;
    case (state_q)
      // DONE accepts start exactly like IDLE so operations can run back to back.
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = a_ns_i;
          cy_d    = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // After WIDTH shifts the first (LSB) sum bit has reached bit 0.
        res_d = {cell_s, res_q[WIDTH-1:1]};
        cy_d  = cell_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign carry  = cy_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         a_ns_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, done, carry;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_ns_i (a_ns_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry)
  );

  always #50 clk = ~clk;

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [W:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    if (op == OP_ADD) r = {1'b0, a} + {1'b0, b};
    else              r = {(a < b), W'(a - b)};
    return r;
  endfunction

  // Present a start at the next falling edge; it is sampled by the following rising edge.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; a_ns_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start = 1'b0; a_i = $urandom; b_i = $urandom; a_ns_i = $urandom;
  endtask

  // Called at the first falling edge after the accepting edge; lat counts from there.
  task automatic wait_done(input string name, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    logic [W:0] exp;
    exp = model(op, a, b);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, W + 1);
    end
    checks++;
    if (result !== exp[W-1:0] || carry !== exp[W]) begin
      errors++;
      $display("FAIL %s result got %h/%b want %h/%b", name, result, carry, exp[W-1:0], exp[W]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done got %b want 0", name, busy);
    end
  endtask

  task automatic run_op(input string name, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] exp;
    exp = model(op, a, b);
    issue(op, a, b);
    wait_done(name, op, a, b);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp[W-1:0] || carry !== exp[W]) begin
      errors++;
      $display("FAIL %s after_done got d%b b%b %h/%b want d0 b0 %h/%b", name, done, busy, result, carry, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_reset;
    #20;
    checks++;
    if (busy !== 0 || done !== 0 || result !== '0 || carry !== 0) begin
      errors++;
      $display("FAIL reset got b%b d%b %h/%b want all 0", busy, done, result, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op("add_nc",   OP_ADD, 8'h35, 8'h4A);
    run_op("add_wrap", OP_ADD, 8'hFF, 8'h01);
    run_op("sub_nb",   OP_SUB, 8'h50, 8'h20);
    run_op("sub_b",    OP_SUB, 8'h10, 8'h20);
    run_op("sub_zero", OP_SUB, 8'h00, 8'h00);
    run_op("sub_max",  OP_SUB, 8'h00, 8'hFF);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run_op("random", 1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic test_busy_ignore;
    issue(OP_ADD, 8'h12, 8'h34);
    @(negedge clk);
    @(negedge clk);
    // Third RUN cycle: a competing request with different operands.
    issue(OP_SUB, 8'h01, 8'hF0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore busy got %b want 1", busy);
    end
    // Four falling edges since acceptance already; wait_done expects one.
    begin
      int lat;
      lat = 4;
      while (!done && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != W + 1 || result !== 8'h46 || carry !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore got lat %0d %h/%b want lat %0d 46/0", lat, result, carry, W + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(OP_ADD, 8'hC0, 8'h50);
    wait_done("b2b_first", OP_ADD, 8'hC0, 8'h50);
    // Still in the DONE cycle: request the next operation right away.
    issue(OP_SUB, 8'h33, 8'h44);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start got b%b d%b want b1 d0", busy, done);
    end
    wait_done("b2b_second", OP_SUB, 8'h33, 8'h44);
    @(negedge clk);
  endtask

  task automatic test_hold;
    logic [W:0] exp;
    exp = model(OP_SUB, 8'h33, 8'h44);
    for (int i = 0; i < 6; i++) begin
      a_i = $urandom; b_i = $urandom; a_ns_i = $urandom;
      @(negedge clk);
      checks++;
      if (result !== exp[W-1:0] || carry !== exp[W] || busy !== 0 || done !== 0) begin
        errors++;
        $display("FAIL hold got %h/%b b%b d%b want %h/%b b0 d0", result, carry, busy, done, exp[W-1:0], exp[W]);
      end
    end
  endtask

  task automatic test_reset_mid;
    issue(OP_ADD, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #10 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || result !== '0 || carry !== 0) begin
      errors++;
      $display("FAIL reset_mid got b%b d%b %h/%b want all 0", busy, done, result, carry);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 0 || result !== '0) begin
      errors++;
      $display("FAIL reset_hold got b%b %h want b0 00", busy, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset", OP_ADD, 8'h01, 8'h01);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
